song_byte_streamer: RTL and testbench

SONG_BYTE_STREAMER -- requirements
Module: song_byte_streamer

---
 rtl/song_byte_streamer.sv | 229 ++++++++++++++++++++++
 tb/tb_song_byte_streamer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_byte_streamer.sv
// AXI4-Lite controlled byte FIFO that paces bytes out on a byte stream, with optional replay loop.
// Register reads respond one cycle after ARREADY; TVALID holds until TREADY, and a loop-mode handshake stalls DATA writes.
module song_byte_streamer #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 16,
    parameter int DIV_W              = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [7:0]                      M_BYTE_TDATA,
    output logic                            M_BYTE_TVALID,
    input  logic                            M_BYTE_TREADY,
    output logic                            IRQ
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic             en_q, loop_q, irq_en_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pace_q, pace_d;
    logic             tick_q, tick_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             hold_q, hold_d;
    logic             flush_pend_q, flush_pend_d;
    logic             bvalid_q, rvalid_q, irq_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       mem [FIFO_DEPTH];

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [7:0]       mem_wdat;
    logic [7:0]       head;
    logic             empty, full, tvalid, hs;
    logic [1:0]       aw_sel, ar_sel;
    logic             wr_req, wr_block, wr_acc, ar_acc;
    logic             ctrl_wr, data_wr, div_wr, stat_wr, flush_wr, flush_now;
    logic             unused_bits;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == DEPTH_C);
    assign head   = mem[rd_q];
    // A deferred flush suppresses new TVALID so the flush lands on an idle stream.
    assign tvalid = hold_q | (en_q & tick_q & ~empty & ~flush_pend_q);
    assign hs     = tvalid & M_BYTE_TREADY;

    assign aw_sel   = S_AXI_AWADDR[3:2];
    assign ar_sel   = S_AXI_ARADDR[3:2];
    assign wr_req   = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~ARESET;
    assign wr_block = loop_q & hs & (aw_sel == 2'd1);
    assign wr_acc   = wr_req & ~wr_block;
    assign ar_acc   = S_AXI_ARVALID & ~rvalid_q & ~ARESET;

    assign ctrl_wr  = wr_acc & (aw_sel == 2'd0);
    assign data_wr  = wr_acc & (aw_sel == 2'd1) & S_AXI_WSTRB[0];
    assign div_wr   = wr_acc & (aw_sel == 2'd2);
    assign stat_wr  = wr_acc & (aw_sel == 2'd3);
    assign flush_wr = ctrl_wr & S_AXI_WDATA[2];

    assign flush_now    = (flush_wr | flush_pend_q) & ~tvalid;
    assign flush_pend_d = (flush_wr | flush_pend_q) & tvalid;
    assign hold_d       = tvalid & ~M_BYTE_TREADY;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = wr_q;
        mem_wdat  = S_AXI_WDATA[7:0];
        if (flush_now) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
        if (hs) begin
            rd_d = rd_q + PW'(1);
            if (loop_q) begin
                mem_we    = 1'b1;
                mem_waddr = wr_q;
                mem_wdat  = head;
                wr_d      = wr_q + PW'(1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        // Evaluated after pop/flush so a push into a full FIFO that pops this cycle succeeds.
        if (data_wr) begin
            if (cnt_d != DEPTH_C) begin
                mem_we    = 1'b1;
                mem_waddr = wr_d;
                mem_wdat  = S_AXI_WDATA[7:0];
                wr_d      = wr_d + PW'(1);
                cnt_d     = cnt_d + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (stat_wr && S_AXI_WDATA[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        pace_d = pace_q;
        tick_d = tick_q;
        // The handshake cycle itself counts as pacing count 0.
        if (hs) begin
            if (div_q == '0) begin
                tick_d = 1'b1;
                pace_d = '0;
            end else begin
                tick_d = 1'b0;
                pace_d = DIV_W'(1);
            end
        end else if (en_q) begin
            if (pace_q >= div_q) begin
                tick_d = 1'b1;
                pace_d = '0;
            end else begin
                pace_d = pace_q + DIV_W'(1);
            end
        end
        if (flush_now) begin
            tick_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = 32'h0;
        case (ar_sel)
            2'd0:    rdata_d = {28'h0, irq_en_q, 1'b0, loop_q, en_q};
            2'd2:    rdata_d = 32'(div_q);
            2'd3:    rdata_d = {16'h0, 8'(cnt_q), 5'h0, ovf_q, full, empty};
            default: rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            en_q         <= 1'b0;
            loop_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            div_q        <= '0;
            pace_q       <= '0;
            tick_q       <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            hold_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
            irq_q        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_q     <= S_AXI_WDATA[0];
                loop_q   <= S_AXI_WDATA[1];
                irq_en_q <= S_AXI_WDATA[3];
            end
            if (div_wr) begin
                div_q <= S_AXI_WDATA[DIV_W-1:0];
            end
            pace_q       <= pace_d;
            tick_q       <= tick_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            hold_q       <= hold_d;
            flush_pend_q <= flush_pend_d;
            if (wr_acc) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            irq_q <= irq_en_q & en_q & empty & ~loop_q;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    assign S_AXI_AWREADY = wr_acc;
    assign S_AXI_WREADY  = wr_acc;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_acc;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign M_BYTE_TVALID = tvalid;
    assign M_BYTE_TDATA  = tvalid ? head : 8'h00;
    assign IRQ           = irq_q;

    assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};
endmodule

// File: tb/tb_song_byte_streamer.sv
// Scoreboard bench for song_byte_streamer: AXI-Lite register traffic plus a byte-stream monitor.
module tb_song_byte_streamer;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic [7:0]  M_BYTE_TDATA;
    logic        M_BYTE_TVALID;
    logic        M_BYTE_TREADY = 1'b0;
    logic        IRQ;

    song_byte_streamer #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .FIFO_DEPTH(16),
        .DIV_W(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .M_BYTE_TDATA(M_BYTE_TDATA), .M_BYTE_TVALID(M_BYTE_TVALID), .M_BYTE_TREADY(M_BYTE_TREADY),
        .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_hs = 0;
    int hs_cnt = 0;
    int exp_intv = 0;
    bit intv_on = 1'b0;
    bit first_hs = 1'b1;
    bit model_loop = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Stream monitor: inputs only change just after posedge, so a negedge sample predicts the next edge.
    always @(negedge ACLK) begin : stream_mon
        logic [7:0] b;
        if (!ARESET && M_BYTE_TVALID && M_BYTE_TREADY) begin
            if (exp_q.size() == 0) begin
                chk_eq("stream_extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                chk_eq("stream_byte", {24'h0, M_BYTE_TDATA}, {24'h0, b});
                if (model_loop) exp_q.push_back(b);
            end
            if (intv_on && !first_hs) chk_eq("hs_interval", cyc - last_hs, exp_intv);
            first_hs = 1'b0;
            last_hs  = cyc;
            hs_cnt++;
        end
    end

    task automatic drv_edge();
        @(posedge ACLK);
        #2;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok = 1'b0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) ok = 1'b1;
        end
        chk_eq("aw_accept", {31'h0, ok}, 32'd1);
        drv_edge();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) ok = 1'b1;
        end
        chk_eq("b_valid", {31'h0, ok}, 32'd1);
        chk_eq("b_resp", {30'h0, S_AXI_BRESP}, 32'd0);
        drv_edge();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
        bit ok = 1'b0;
        d = 32'hDEAD_BEEF;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) ok = 1'b1;
        end
        chk_eq("ar_accept", {31'h0, ok}, 32'd1);
        drv_edge();
        S_AXI_ARVALID = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin
                ok = 1'b1;
                d  = S_AXI_RDATA;
            end
        end
        chk_eq("r_valid", {31'h0, ok}, 32'd1);
        chk_eq("r_resp", {30'h0, S_AXI_RRESP}, 32'd0);
        drv_edge();
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        chk_eq(tag, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_out);
        axi_write(4'h4, {24'h0, b}, 4'h1);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge ACLK);
        chk_eq("drain_done", 32'(exp_q.size()), 32'd0);
        drv_edge();
    endtask

    task automatic wait_hs(input int n, input int budget);
        int base = hs_cnt;
        for (int i = 0; i < budget && (hs_cnt - base) < n; i++) @(negedge ACLK);
        chk_eq("hs_progress", {31'h0, (hs_cnt - base) >= n}, 32'd1);
        drv_edge();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] held;
        // Reset state, including readies held low with requests pending.
        repeat (2) @(negedge ACLK);
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        chk_eq("rst_awready", {31'h0, S_AXI_AWREADY}, 32'd0);
        chk_eq("rst_arready", {31'h0, S_AXI_ARREADY}, 32'd0);
        chk_eq("rst_tvalid", {31'h0, M_BYTE_TVALID}, 32'd0);
        chk_eq("rst_tdata", {24'h0, M_BYTE_TDATA}, 32'd0);
        chk_eq("rst_irq", {31'h0, IRQ}, 32'd0);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        drv_edge();
        ARESET = 1'b0;
        rd_chk("status_reset", 4'hC, 32'h0000_0001);
        rd_chk("ctrl_reset", 4'h0, 32'h0);
        rd_chk("div_reset", 4'h8, 32'h0);
        rd_chk("data_reads0", 4'h4, 32'h0);

        // Paced drain with DIV=3: one byte every 4 cycles.
        axi_write(4'h8, 32'd3, 4'hF);
        rd_chk("div_rb", 4'h8, 32'd3);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        rd_chk("status_3", 4'hC, 32'h0000_0300);
        M_BYTE_TREADY = 1'b1;
        exp_intv = 4;
        first_hs = 1'b1;
        intv_on  = 1'b1;
        axi_write(4'h0, 32'h1, 4'hF);
        wait_drain(300);
        intv_on = 1'b0;
        rd_chk("status_drained", 4'hC, 32'h0000_0001);
        axi_write(4'h0, 32'h0, 4'hF);

        // Overflow, W1C, strobe gating and flush.
        for (int i = 0; i < 17; i++) push_byte(8'h40 + 8'(i), i < 16);
        rd_chk("status_ovf", 4'hC, 32'h0000_1006);
        axi_write(4'hC, 32'h4, 4'hF);
        rd_chk("status_ovf_clr", 4'hC, 32'h0000_1002);
        axi_write(4'h0, 32'h4, 4'hF);
        exp_q.delete();
        rd_chk("status_flush", 4'hC, 32'h0000_0001);
        rd_chk("ctrl_flush_rd0", 4'h0, 32'h0);
        axi_write(4'h4, 32'h55, 4'hE);
        rd_chk("status_nostrb", 4'hC, 32'h0000_0001);

        // Loop replay at DIV=0, then backpressure hold.
        push_byte(8'hA0, 1'b1);
        push_byte(8'hA1, 1'b1);
        axi_write(4'h8, 32'd0, 4'hF);
        model_loop = 1'b1;
        exp_intv   = 1;
        first_hs   = 1'b1;
        intv_on    = 1'b1;
        axi_write(4'h0, 32'h3, 4'hF);
        wait_hs(12, 200);
        rd_chk("status_loop", 4'hC, 32'h0000_0200);
        intv_on = 1'b0;
        M_BYTE_TREADY = 1'b0;
        @(negedge ACLK);
        held = M_BYTE_TDATA;
        chk_eq("hold_head", {24'h0, held}, {24'h0, exp_q[0]});
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk_eq("hold_tvalid", {31'h0, M_BYTE_TVALID}, 32'd1);
            chk_eq("hold_tdata", {24'h0, M_BYTE_TDATA}, {24'h0, held});
        end
        drv_edge();
        axi_write(4'h0, 32'h2, 4'hF);
        @(negedge ACLK);
        chk_eq("hold_after_dis_vld", {31'h0, M_BYTE_TVALID}, 32'd1);
        chk_eq("hold_after_dis_dat", {24'h0, M_BYTE_TDATA}, {24'h0, held});
        drv_edge();
        M_BYTE_TREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        chk_eq("drop_after_dis", {31'h0, M_BYTE_TVALID}, 32'd0);
        drv_edge();
        axi_write(4'h0, 32'h4, 4'hF);
        model_loop = 1'b0;
        exp_q.delete();
        rd_chk("status_loop_flush", 4'hC, 32'h0000_0001);

        // IRQ follows empty by one cycle.
        M_BYTE_TREADY = 1'b0;
        axi_write(4'h0, 32'h9, 4'hF);
        @(negedge ACLK);
        chk_eq("irq_idle", {31'h0, IRQ}, 32'd1);
        drv_edge();
        push_byte(8'h77, 1'b1);
        @(negedge ACLK);
        chk_eq("irq_busy", {31'h0, IRQ}, 32'd0);
        chk_eq("tvalid_busy", {31'h0, M_BYTE_TVALID}, 32'd1);
        drv_edge();
        M_BYTE_TREADY = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk_eq("irq_lag", {31'h0, IRQ}, 32'd0);
        chk_eq("tvalid_drained", {31'h0, M_BYTE_TVALID}, 32'd0);
        @(negedge ACLK);
        chk_eq("irq_rise", {31'h0, IRQ}, 32'd1);
        chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-transfer and while IRQ is high.
        drv_edge();
        M_BYTE_TREADY = 1'b0;
        push_byte(8'h88, 1'b0);
        @(negedge ACLK);
        chk_eq("pre_rst_tvalid", {31'h0, M_BYTE_TVALID}, 32'd1);
        chk_eq("pre_rst_tdata", {24'h0, M_BYTE_TDATA}, 32'h88);
        #2 ARESET = 1'b1;
        #1;
        chk_eq("arst_tvalid", {31'h0, M_BYTE_TVALID}, 32'd0);
        chk_eq("arst_tdata", {24'h0, M_BYTE_TDATA}, 32'd0);
        drv_edge();
        drv_edge();
        ARESET = 1'b0;
        axi_write(4'h0, 32'h9, 4'hF);
        @(negedge ACLK);
        chk_eq("irq_before_arst", {31'h0, IRQ}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        chk_eq("arst_irq", {31'h0, IRQ}, 32'd0);
        drv_edge();
        ARESET = 1'b0;
        rd_chk("status_post_rst", 4'hC, 32'h0000_0001);
        rd_chk("ctrl_post_rst", 4'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
